cpu_prog_driver: RTL and testbench

- Host-side driver for the 8-bit cpu. It holds a 16-word program buffer, loaded through a simple write port.
- On `start`, it resets the cpu, then streams opcode and operand words onto the cpu's `in` bus. Each opcode is padded with idle cycles to match the cpu control FSM's multi-cycle sequences.
- It captures the cpu `out` value after each output-class instruction into a 4-deep result FIFO that the testbench or SoC reads.

---
 rtl/cpu_prog_driver_if.sv | 25 ++
 rtl/cpu_prog_driver.sv | 128 ++++++++++++
 tb/tb_cpu_prog_driver.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cpu_prog_driver_if.sv
// cpu_prog_driver_if: host load/start/result port and cpu-facing bus of the program driver.
interface cpu_prog_driver_if #(parameter int AW = 4) ();
  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [7:0]    load_data;
  logic          start;
  logic [AW:0]   prog_len;
  logic [7:0]    cpu_in;
  logic          cpu_reset;
  logic [7:0]    cpu_out;
  logic          busy;
  logic          done;
  logic          err;
  logic          res_valid;
  logic [7:0]    res_data;
  logic          res_pop;
  modport master (
    output load_we, load_addr, load_data, start, prog_len, cpu_out, res_pop,
    input  cpu_in, cpu_reset, busy, done, err, res_valid, res_data
  );
  modport slave (
    input  load_we, load_addr, load_data, start, prog_len, cpu_out, res_pop,
    output cpu_in, cpu_reset, busy, done, err, res_valid, res_data
  );
endinterface

// File: rtl/cpu_prog_driver.sv
// cpu_prog_driver: streams a buffered program into the 8-bit cpu with per-opcode padding and collects outputs.
module cpu_prog_driver #(
  parameter int         DEPTH     = 16,
  parameter int         AW        = 4,
  parameter logic [7:0] FILL      = 8'hF0,
  parameter int         RES_DEPTH = 4,
  parameter int         RST_CYC   = 2
) (
  input logic clk,
  input logic rst_n,
  cpu_prog_driver_if.slave bus
);
  localparam int RW = $clog2(RES_DEPTH);
  typedef enum logic [2:0] {IDLE, CRST, ISSUE, OPND, PAD, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW:0]   pc_q, pc_d, len_q, len_d;
  logic [1:0]    pad_q, pad_d;
  logic [7:0]    rcnt_q, rcnt_d;
  logic          out_q, out_d, err_q, err_d, done_q;
  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    res_q [RES_DEPTH];
  logic [RW-1:0] wp_q, rp_q;
  logic [RW:0]   cnt_q;
  logic [7:0]    word, cpu_in_c;
  logic [3:0]    op;
  logic [1:0]    npad;
  logic          opnd, len_ok, busy, cpu_rst_c, push, pop, full, push_ok, ovf;
  assign word    = mem_q[pc_q[AW-1:0]];
  assign op      = word[7:4];
  assign opnd    = op == 4'h6 || op == 4'h7 || op == 4'h8;
  assign npad    = op == 4'h9 || op == 4'hE ? 2'd1 :
                   op == 4'hB ? 2'd2 :
                   op == 4'hA || op == 4'hC || op == 4'hD ? 2'd3 : 2'd0;
  assign len_ok  = bus.prog_len != '0 && bus.prog_len <= (AW+1)'(DEPTH);
  assign busy    = state_q != IDLE && state_q != DONE;
  assign full    = cnt_q == (RW+1)'(RES_DEPTH);
  assign pop     = bus.res_pop && cnt_q != '0;
  assign push_ok = push && (!full || pop);
  assign ovf     = push && full && !bus.res_pop;
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    pad_d     = pad_q;
    rcnt_d    = rcnt_q;
    out_d     = out_q;
    err_d     = err_q;
    cpu_in_c  = FILL;
    cpu_rst_c = 1'b1;
    push      = 1'b0;
    case (state_q)
      IDLE, DONE: if (bus.start) begin
        err_d = !len_ok;
        if (len_ok) begin
          state_d = CRST;
          pc_d    = '0;
          len_d   = bus.prog_len;
          rcnt_d  = '0;
        end
      end
      CRST: begin
        rcnt_d  = rcnt_q + 8'd1;
        state_d = rcnt_q == 8'(RST_CYC - 1) ? ISSUE : CRST;
      end
      ISSUE: begin
        cpu_rst_c = 1'b0;
        cpu_in_c  = word;
        pc_d      = pc_q + 1'b1;
        out_d     = op == 4'hB;
        pad_d     = npad;
        // operand and pad words finish their sequence even when they are the last word
        state_d   = opnd ? OPND : npad != 2'd0 ? PAD : pc_d == len_q ? DONE : ISSUE;
      end
      OPND: begin
        cpu_rst_c = 1'b0;
        cpu_in_c  = pc_q < len_q ? word : FILL;
        pc_d      = pc_q < len_q ? pc_q + 1'b1 : pc_q;
        err_d     = err_q || pc_q >= len_q;
        state_d   = pc_d >= len_q ? DONE : ISSUE;
      end
      PAD: begin
        cpu_rst_c = 1'b0;
        pad_d     = pad_q - 2'd1;
        push      = out_q && pad_q == 2'd1;
        state_d   = pad_q != 2'd1 ? PAD : pc_q == len_q ? DONE : ISSUE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      pad_q   <= '0;
      rcnt_q  <= '0;
      out_q   <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      pad_q   <= pad_d;
      rcnt_q  <= rcnt_d;
      out_q   <= out_d;
      err_q   <= err_d || ovf;
      done_q  <= state_d == DONE && state_q != DONE;
      wp_q    <= wp_q + RW'(push_ok);
      rp_q    <= rp_q + RW'(pop);
      cnt_q   <= cnt_q + (RW+1)'(push_ok) - (RW+1)'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (bus.load_we && !busy) mem_q[bus.load_addr] <= bus.load_data;
    if (push_ok) res_q[wp_q] <= bus.cpu_out;
  end
  assign bus.cpu_in    = cpu_in_c;
  assign bus.cpu_reset = cpu_rst_c;
  assign bus.busy      = busy;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.res_valid = cnt_q != '0;
  assign bus.res_data  = cnt_q != '0 ? res_q[rp_q] : 8'h00;
endmodule

// File: tb/tb_cpu_prog_driver.sv
// tb_cpu_prog_driver: directed scenario tests for the cpu program driver.
module tb_cpu_prog_driver;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int ncmp = 0;
  int nerr = 0;
  logic [7:0] seq[$];
  int nrst;
  bit got_done;
  logic [7:0] out_next;
  cpu_prog_driver_if #(.AW(4)) bus ();
  cpu_prog_driver dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic load_prog(input logic [7:0] p[$]);
    for (int i = 0; i < p.size(); i++) begin
      bus.load_we = 1'b1;
      bus.load_addr = 4'(i);
      bus.load_data = p[i];
      @(negedge clk);
    end
    bus.load_we = 1'b0;
  endtask
  task automatic start_run(input logic [4:0] len);
    bus.prog_len = len;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask
  // Records cpu_in for every driven cycle until done; feeds cpu_out per B0 issue.
  task automatic collect(input bit glitch, input bit pop_at_push);
    int since = 99;
    seq.delete();
    nrst = 0;
    got_done = 0;
    for (int i = 0; i < 200 && !got_done; i++) begin
      if (bus.done) got_done = 1;
      else begin
        if (bus.busy && bus.cpu_reset) nrst++;
        if (bus.busy && !bus.cpu_reset) begin
          seq.push_back(bus.cpu_in);
          if (bus.cpu_in == 8'hB0) begin
            bus.cpu_out = out_next;
            out_next++;
            since = 0;
          end else since++;
        end
        bus.res_pop = pop_at_push && since == 2;
        bus.start = glitch;
        @(negedge clk);
      end
    end
    bus.start = 1'b0;
    bus.res_pop = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    ncmp++; if (bus.cpu_in !== 8'hF0) begin nerr++; $display("FAIL rst_cpu_in got %h exp f0", bus.cpu_in); end
    ncmp++; if (bus.cpu_reset !== 1'b1) begin nerr++; $display("FAIL rst_cpu_reset got %b exp 1", bus.cpu_reset); end
    ncmp++; if ({bus.busy, bus.done, bus.err, bus.res_valid} !== 4'b0) begin nerr++; $display("FAIL rst_flags got %b exp 0000", {bus.busy, bus.done, bus.err, bus.res_valid}); end
    ncmp++; if (bus.res_data !== 8'h00) begin nerr++; $display("FAIL rst_res_data got %h exp 00", bus.res_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_operand;
    logic [7:0] p[$];
    p = '{8'h61, 8'h05, 8'h72, 8'h03, 8'h10};
    load_prog(p);
    start_run(5'd5);
    collect(0, 0);
    ncmp++; if (!got_done) begin nerr++; $display("FAIL opnd_done got 0 exp 1"); end
    ncmp++; if (nrst !== 2) begin nerr++; $display("FAIL opnd_rst_cycles got %0d exp 2", nrst); end
    ncmp++; if (seq.size() !== 5) begin nerr++; $display("FAIL opnd_len got %0d exp 5", seq.size()); end
    for (int i = 0; i < 5 && i < seq.size(); i++) begin
      ncmp++; if (seq[i] !== p[i]) begin nerr++; $display("FAIL opnd_word%0d got %h exp %h", i, seq[i], p[i]); end
    end
    ncmp++; if (bus.err !== 1'b0 || bus.busy !== 1'b0) begin nerr++; $display("FAIL opnd_err_busy got %b%b exp 00", bus.err, bus.busy); end
    @(negedge clk);
    ncmp++; if (bus.done !== 1'b0) begin nerr++; $display("FAIL opnd_done_pulse got %b exp 0", bus.done); end
  endtask
  task automatic test_output;
    logic [7:0] p[$];
    logic [7:0] e[$];
    p = '{8'hB0};
    e = '{8'hB0, 8'hF0, 8'hF0};
    load_prog(p);
    out_next = 8'h5A;
    start_run(5'd1);
    collect(0, 0);
    ncmp++; if (!got_done || seq.size() !== 3) begin nerr++; $display("FAIL out_len got %0d/%0d exp 1/3", got_done, seq.size()); end
    for (int i = 0; i < 3 && i < seq.size(); i++) begin
      ncmp++; if (seq[i] !== e[i]) begin nerr++; $display("FAIL out_word%0d got %h exp %h", i, seq[i], e[i]); end
    end
    ncmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h5A) begin nerr++; $display("FAIL out_fifo got %b/%h exp 1/5a", bus.res_valid, bus.res_data); end
    bus.res_pop = 1'b1;
    @(negedge clk);
    bus.res_pop = 1'b0;
    ncmp++; if (bus.res_valid !== 1'b0) begin nerr++; $display("FAIL out_pop got %b exp 0", bus.res_valid); end
  endtask
  task automatic test_trunc;
    logic [7:0] p[$];
    p = '{8'h60};
    load_prog(p);
    start_run(5'd1);
    collect(0, 0);
    ncmp++; if (!got_done) begin nerr++; $display("FAIL trunc_done got 0 exp 1"); end
    ncmp++; if (seq.size() !== 2) begin nerr++; $display("FAIL trunc_len got %0d exp 2", seq.size()); end
    ncmp++; if (seq.size() == 2 && (seq[0] !== 8'h60 || seq[1] !== 8'hF0)) begin nerr++; $display("FAIL trunc_words got %h %h exp 60 f0", seq[0], seq[1]); end
    ncmp++; if (bus.err !== 1'b1) begin nerr++; $display("FAIL trunc_err got %b exp 1", bus.err); end
  endtask
  task automatic test_overflow;
    logic [7:0] p[$];
    p = '{8'hB0, 8'hB0, 8'hB0, 8'hB0, 8'hB0};
    load_prog(p);
    out_next = 8'h11;
    start_run(5'd5);
    collect(0, 0);
    ncmp++; if (!got_done || seq.size() !== 15) begin nerr++; $display("FAIL ovf_len got %0d/%0d exp 1/15", got_done, seq.size()); end
    ncmp++; if (bus.err !== 1'b1) begin nerr++; $display("FAIL ovf_err got %b exp 1", bus.err); end
    for (int i = 0; i < 4; i++) begin
      ncmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'(8'h11 + i)) begin nerr++; $display("FAIL ovf_head%0d got %b/%h exp 1/%h", i, bus.res_valid, bus.res_data, 8'(8'h11 + i)); end
      bus.res_pop = 1'b1;
      @(negedge clk);
      bus.res_pop = 1'b0;
    end
    ncmp++; if (bus.res_valid !== 1'b0) begin nerr++; $display("FAIL ovf_empty got %b exp 0", bus.res_valid); end
  endtask
  task automatic test_push_pop_full;
    out_next = 8'h21;
    start_run(5'd4);
    collect(0, 0);
    ncmp++; if (bus.err !== 1'b0 || bus.res_data !== 8'h21) begin nerr++; $display("FAIL full_fill got %b/%h exp 0/21", bus.err, bus.res_data); end
    start_run(5'd1);
    collect(0, 1);
    ncmp++; if (bus.err !== 1'b0) begin nerr++; $display("FAIL full_pushpop_err got %b exp 0", bus.err); end
    for (int i = 0; i < 4; i++) begin
      ncmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'(8'h22 + i)) begin nerr++; $display("FAIL full_head%0d got %b/%h exp 1/%h", i, bus.res_valid, bus.res_data, 8'(8'h22 + i)); end
      bus.res_pop = 1'b1;
      @(negedge clk);
      bus.res_pop = 1'b0;
    end
    ncmp++; if (bus.res_valid !== 1'b0) begin nerr++; $display("FAIL full_empty got %b exp 0", bus.res_valid); end
  endtask
  task automatic test_back_to_back;
    logic [7:0] p[$];
    logic [7:0] e[$];
    p = '{8'hA0, 8'h20};
    e = '{8'hA0, 8'hF0, 8'hF0, 8'hF0, 8'h20};
    load_prog(p);
    start_run(5'd2);
    collect(1, 0);
    ncmp++; if (!got_done || seq.size() !== 5) begin nerr++; $display("FAIL pad_len got %0d/%0d exp 1/5", got_done, seq.size()); end
    for (int i = 0; i < 5 && i < seq.size(); i++) begin
      ncmp++; if (seq[i] !== e[i]) begin nerr++; $display("FAIL pad_word%0d got %h exp %h", i, seq[i], e[i]); end
    end
    ncmp++; if (bus.err !== 1'b0) begin nerr++; $display("FAIL pad_err got %b exp 0", bus.err); end
    @(negedge clk);
    ncmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin nerr++; $display("FAIL pad_after got %b%b exp 00", bus.busy, bus.done); end
  endtask
  task automatic test_async_reset;
    logic [7:0] p[$];
    p = '{8'hB0};
    load_prog(p);
    out_next = 8'h77;
    start_run(5'd1);
    collect(0, 0);
    ncmp++; if (bus.res_valid !== 1'b1) begin nerr++; $display("FAIL ar_pre_valid got %b exp 1", bus.res_valid); end
    p = '{8'h10, 8'h10, 8'h10, 8'h10};
    load_prog(p);
    start_run(5'd4);
    @(negedge clk);
    @(negedge clk);
    ncmp++; if (bus.cpu_reset !== 1'b0 || bus.cpu_in !== 8'h10 || bus.busy !== 1'b1) begin nerr++; $display("FAIL ar_issue got %b/%h/%b exp 0/10/1", bus.cpu_reset, bus.cpu_in, bus.busy); end
    rst_n = 1'b0;
    #1;
    ncmp++; if (bus.cpu_reset !== 1'b1 || bus.busy !== 1'b0 || bus.cpu_in !== 8'hF0) begin nerr++; $display("FAIL ar_abort got %b/%b/%h exp 1/0/f0", bus.cpu_reset, bus.busy, bus.cpu_in); end
    ncmp++; if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00) begin nerr++; $display("FAIL ar_fifo got %b/%h exp 0/00", bus.res_valid, bus.res_data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_run(5'd0);
    ncmp++; if (bus.err !== 1'b1 || bus.busy !== 1'b0) begin nerr++; $display("FAIL ar_badlen got %b/%b exp 1/0", bus.err, bus.busy); end
    @(negedge clk);
    @(negedge clk);
    ncmp++; if (bus.busy !== 1'b0 || bus.cpu_reset !== 1'b1 || bus.cpu_in !== 8'hF0) begin nerr++; $display("FAIL ar_idle got %b/%b/%h exp 0/1/f0", bus.busy, bus.cpu_reset, bus.cpu_in); end
  endtask
  initial begin
    bus.load_we = 1'b0;
    bus.load_addr = '0;
    bus.load_data = '0;
    bus.start = 1'b0;
    bus.prog_len = '0;
    bus.cpu_out = '0;
    bus.res_pop = 1'b0;
    out_next = '0;
    test_reset();
    test_operand();
    test_output();
    test_trunc();
    test_overflow();
    test_push_pop_full();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
